blit_text_seq: RTL and testbench

Row sequencer for the blitter's p1 stage, directly upstream of the text address stage. It accepts a blit command, and in text mode also a stream of character codes. For each character it walks the font glyph rows, emitting one p1 beat per row: glyph-row source address, character code, font bytes-per-char, textmode flag and destination coordinates. The next stage adds `char * font_bpc` to the address. In rectangle mode it walks the rows of a plain source rectangle instead.

---
 rtl/blit_text_seq_if.sv | 78 +++++++
 rtl/blit_text_seq.sv | 145 ++++++++++++++
 tb/tb_blit_text_seq.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/blit_text_seq_if.sv
// Command, character and p1 beat bundle for the blitter text sequencer.
// The driver owns cmd/char, the sequencer owns the ready lines and p1 beats.
interface blit_text_seq_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_textmode;
  logic [25:0] cmd_src_base;
  logic [15:0] cmd_src_stride;
  logic [7:0]  cmd_font_bpc;
  logic [7:0]  cmd_width;
  logic [7:0]  cmd_height;
  logic [15:0] cmd_dst_x;
  logic [15:0] cmd_dst_y;

  logic        char_valid;
  logic        char_ready;
  logic [7:0]  char_data;
  logic        char_last;

  logic        p1_valid;
  logic [25:0] p1_src_addr;
  logic [7:0]  p1_char;
  logic [7:0]  p1_font_bpc;
  logic        p1_textmode;
  logic [15:0] p1_dst_x;
  logic [15:0] p1_dst_y;
  logic        p1_last;

  modport master (
    output cmd_valid,
    output cmd_textmode,
    output cmd_src_base,
    output cmd_src_stride,
    output cmd_font_bpc,
    output cmd_width,
    output cmd_height,
    output cmd_dst_x,
    output cmd_dst_y,
    output char_valid,
    output char_data,
    output char_last,
    input  cmd_ready,
    input  char_ready,
    input  p1_valid,
    input  p1_src_addr,
    input  p1_char,
    input  p1_font_bpc,
    input  p1_textmode,
    input  p1_dst_x,
    input  p1_dst_y,
    input  p1_last
  );

  modport slave (
    input  cmd_valid,
    input  cmd_textmode,
    input  cmd_src_base,
    input  cmd_src_stride,
    input  cmd_font_bpc,
    input  cmd_width,
    input  cmd_height,
    input  cmd_dst_x,
    input  cmd_dst_y,
    input  char_valid,
    input  char_data,
    input  char_last,
    output cmd_ready,
    output char_ready,
    output p1_valid,
    output p1_src_addr,
    output p1_char,
    output p1_font_bpc,
    output p1_textmode,
    output p1_dst_x,
    output p1_dst_y,
    output p1_last
  );
endinterface

// File: rtl/blit_text_seq.sv
// Blitter p1 row sequencer: walks glyph rows per character (text mode)
// or source rows of a plain rectangle, emitting one p1 beat per row.
module blit_text_seq (
  input  logic            clock,
  input  logic            resetn,
  input  logic            stall,
  output logic            busy,
  blit_text_seq_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    TEXT  = 2'd2,
    RECT  = 2'd3
  } state_t;

  state_t      state;

  logic        tm_q;
  logic [25:0] base_q;
  logic [15:0] stride_q;
  logic [7:0]  bpc_q;
  logic [7:0]  width_q;
  logic [7:0]  height_q;
  logic [15:0] dst_x_q;
  logic [15:0] dst_y_q;

  logic [7:0]  row_q;
  logic [25:0] addr_q;
  logic [15:0] x_q;
  logic [7:0]  ch_q;
  logic        ch_last_q;

  logic        last_row;
  logic [25:0] addr_nxt;
  logic [15:0] y_row;

  assign last_row = row_q == (height_q - 8'd1);
  assign addr_nxt = addr_q + {10'd0, stride_q};
  assign y_row    = dst_y_q + {8'd0, row_q};

  assign bus.cmd_ready  = (state == IDLE) & ~stall;
  assign bus.char_ready = (state == FETCH) & ~stall;
  assign busy           = state != IDLE;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state           <= IDLE;
      tm_q            <= 1'b0;
      base_q          <= '0;
      stride_q        <= '0;
      bpc_q           <= '0;
      width_q         <= '0;
      height_q        <= '0;
      dst_x_q         <= '0;
      dst_y_q         <= '0;
      row_q           <= '0;
      addr_q          <= '0;
      x_q             <= '0;
      ch_q            <= '0;
      ch_last_q       <= 1'b0;
      bus.p1_valid    <= 1'b0;
      bus.p1_src_addr <= '0;
      bus.p1_char     <= '0;
      bus.p1_font_bpc <= '0;
      bus.p1_textmode <= 1'b0;
      bus.p1_dst_x    <= '0;
      bus.p1_dst_y    <= '0;
      bus.p1_last     <= 1'b0;
    end else if (!stall) begin
      unique case (state)
        IDLE: begin
          bus.p1_valid <= 1'b0;
          bus.p1_last  <= 1'b0;
          if (bus.cmd_valid) begin
            tm_q     <= bus.cmd_textmode;
            base_q   <= bus.cmd_src_base;
            stride_q <= bus.cmd_src_stride;
            bpc_q    <= bus.cmd_font_bpc;
            width_q  <= bus.cmd_width;
            height_q <= bus.cmd_height;
            dst_x_q  <= bus.cmd_dst_x;
            dst_y_q  <= bus.cmd_dst_y;
            row_q    <= '0;
            addr_q   <= bus.cmd_src_base;
            x_q      <= bus.cmd_dst_x;
            // zero-height commands retire here without a beat
            if (bus.cmd_height != 8'd0) begin
              state <= bus.cmd_textmode ? FETCH : RECT;
            end
          end
        end
        FETCH: begin
          bus.p1_valid <= 1'b0;
          bus.p1_last  <= 1'b0;
          if (bus.char_valid) begin
            ch_q      <= bus.char_data;
            ch_last_q <= bus.char_last;
            row_q     <= '0;
            addr_q    <= base_q;
            state     <= TEXT;
          end
        end
        TEXT: begin
          bus.p1_valid    <= 1'b1;
          bus.p1_src_addr <= addr_q;
          bus.p1_char     <= ch_q;
          bus.p1_font_bpc <= bpc_q;
          bus.p1_textmode <= tm_q;
          bus.p1_dst_x    <= x_q;
          bus.p1_dst_y    <= y_row;
          bus.p1_last     <= last_row & ch_last_q;
          addr_q          <= addr_nxt;
          row_q           <= row_q + 8'd1;
          if (last_row) begin
            if (ch_last_q) begin
              state <= IDLE;
            end else begin
              x_q   <= x_q + {8'd0, width_q};
              state <= FETCH;
            end
          end
        end
        RECT: begin
          bus.p1_valid    <= 1'b1;
          bus.p1_src_addr <= addr_q;
          bus.p1_char     <= 8'd0;
          bus.p1_font_bpc <= bpc_q;
          bus.p1_textmode <= tm_q;
          bus.p1_dst_x    <= dst_x_q;
          bus.p1_dst_y    <= y_row;
          bus.p1_last     <= last_row;
          addr_q          <= addr_nxt;
          row_q           <= row_q + 8'd1;
          if (last_row) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_blit_text_seq.sv
// Scoreboard bench for blit_text_seq: a row-walk reference model queues
// expected beats, a monitor pops and compares each freshly registered beat.
module tb_blit_text_seq;

  logic clock = 1'b0;
  logic resetn = 1'b0;
  logic stall = 1'b0;
  logic busy;

  blit_text_seq_if bus();

  blit_text_seq dut (
    .clock (clock),
    .resetn(resetn),
    .stall (stall),
    .busy  (busy),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  bit stall_en = 1'b0;
  bit stall_force = 1'b0;

  typedef struct packed {
    logic [25:0] addr;
    logic [7:0]  ch;
    logic [7:0]  bpc;
    logic        tm;
    logic [15:0] x;
    logic [15:0] y;
    logic        last;
  } beat_t;

  typedef struct {
    bit          tm;
    logic [25:0] base;
    logic [15:0] stride;
    logic [7:0]  bpc;
    logic [7:0]  width;
    logic [7:0]  height;
    logic [15:0] dx;
    logic [15:0] dy;
  } cmd_t;

  beat_t exp_q[$];

  always @(negedge clock)
    stall = stall_force || (stall_en && ($urandom_range(0, 99) < 20));

  task automatic check(string name, logic [127:0] got, logic [127:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  function automatic beat_t cur_out();
    return {bus.p1_src_addr, bus.p1_char, bus.p1_font_bpc, bus.p1_textmode,
            bus.p1_dst_x, bus.p1_dst_y, bus.p1_last};
  endfunction

  // reference: every char repeats the glyph row walk from the font base
  function automatic void push_exp(cmd_t c, logic [7:0] chs[$]);
    int n;
    beat_t b;
    if (c.height == 8'd0) return;
    n = c.tm ? chs.size() : 1;
    for (int i = 0; i < n; i++) begin
      for (int r = 0; r < int'(c.height); r++) begin
        b.addr = 26'(32'(c.base) + 32'(r) * 32'(c.stride));
        b.ch   = c.tm ? chs[i] : 8'h00;
        b.bpc  = c.bpc;
        b.tm   = c.tm;
        b.x    = c.tm ? 16'(32'(c.dx) + 32'(i) * 32'(c.width)) : c.dx;
        b.y    = 16'(32'(c.dy) + 32'(r));
        b.last = (i == n - 1) && (r == int'(c.height) - 1);
        exp_q.push_back(b);
      end
    end
  endfunction

  always @(posedge clock) begin : mon
    bit s;
    bit prev_ok;
    bit prev_v;
    beat_t prev_o;
    beat_t cur;
    beat_t e;
    s = stall;
    #1;
    cur = cur_out();
    if (!resetn) begin
      prev_ok = 1'b0;
    end else begin
      if (s) begin
        if (prev_ok)
          check("stall_hold", 128'({cur, bus.p1_valid}), 128'({prev_o, prev_v}));
        check("stall_ready", 128'({bus.cmd_ready, bus.char_ready}), 128'(0));
      end else if (bus.p1_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got %h want no beat", cur);
        end else begin
          e = exp_q.pop_front();
          check("beat", 128'(cur), 128'(e));
        end
      end
      prev_o  = cur;
      prev_v  = bus.p1_valid;
      prev_ok = 1'b1;
    end
  end

  task automatic drive_cmd(cmd_t c);
    int n = 0;
    bit ok = 1'b0;
    @(negedge clock);
    bus.cmd_valid      = 1'b1;
    bus.cmd_textmode   = c.tm;
    bus.cmd_src_base   = c.base;
    bus.cmd_src_stride = c.stride;
    bus.cmd_font_bpc   = c.bpc;
    bus.cmd_width      = c.width;
    bus.cmd_height     = c.height;
    bus.cmd_dst_x      = c.dx;
    bus.cmd_dst_y      = c.dy;
    while (!ok && n < 500) begin
      #1;
      if (bus.cmd_ready) ok = 1'b1;
      else begin
        @(negedge clock);
        n++;
      end
    end
    if (ok) @(posedge clock);
    else begin
      checks++;
      errors++;
      $display("FAIL cmd_timeout: got no cmd_ready want accept in 500 cycles");
    end
    #1 bus.cmd_valid = 1'b0;
  endtask

  task automatic drive_char(logic [7:0] d, bit last, int gap);
    int n = 0;
    bit ok = 1'b0;
    repeat (gap) @(negedge clock);
    @(negedge clock);
    bus.char_valid = 1'b1;
    bus.char_data  = d;
    bus.char_last  = last;
    while (!ok && n < 500) begin
      #1;
      if (bus.char_ready) ok = 1'b1;
      else begin
        @(negedge clock);
        n++;
      end
    end
    if (ok) @(posedge clock);
    else begin
      checks++;
      errors++;
      $display("FAIL char_timeout: got no char_ready want accept in 500 cycles");
    end
    #1 bus.char_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 3000) begin
      @(negedge clock);
      n++;
    end
    check("drain_busy", 128'(busy), 128'(0));
    check("drain_queue", 128'(exp_q.size()), 128'(0));
  endtask

  task automatic run(cmd_t c, logic [7:0] chs[$], int gap);
    push_exp(c, chs);
    drive_cmd(c);
    if (c.tm && c.height != 8'd0)
      for (int i = 0; i < chs.size(); i++)
        drive_char(chs[i], i == chs.size() - 1, gap);
    wait_drain();
  endtask

  function automatic cmd_t mk(bit tm, logic [25:0] base, logic [15:0] stride,
                              logic [7:0] bpc, logic [7:0] w, logic [7:0] h,
                              logic [15:0] dx, logic [15:0] dy);
    cmd_t c;
    c.tm = tm; c.base = base; c.stride = stride; c.bpc = bpc;
    c.width = w; c.height = h; c.dx = dx; c.dy = dy;
    return c;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish want finish before 2ms");
    $fatal(1, "watchdog");
  end

  initial begin
    cmd_t c;
    logic [7:0] chs[$];
    bus.cmd_valid = 0; bus.cmd_textmode = 0; bus.cmd_src_base = 0;
    bus.cmd_src_stride = 0; bus.cmd_font_bpc = 0; bus.cmd_width = 0;
    bus.cmd_height = 0; bus.cmd_dst_x = 0; bus.cmd_dst_y = 0;
    bus.char_valid = 0; bus.char_data = 0; bus.char_last = 0;

    #12;
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_valid", 128'(bus.p1_valid), 128'(0));
    check("rst_p1", 128'(cur_out()), 128'(0));
    @(negedge clock) resetn = 1'b1;

    // rectangle, first beat one edge after accept
    c = mk(0, 26'h100, 16'h40, 8'd4, 8'd0, 8'd3, 16'd5, 16'd7);
    chs = {};
    push_exp(c, chs);
    drive_cmd(c);
    @(posedge clock); #1;
    check("rect_lat", 128'({bus.p1_valid, bus.p1_src_addr}), 128'({1'b1, 26'h100}));
    wait_drain();

    // text string "AB"
    c = mk(1, 26'h2000, 16'd1, 8'd16, 8'd8, 8'd2, 16'h30, 16'd3);
    chs = {8'h41, 8'h42};
    push_exp(c, chs);
    drive_cmd(c);
    drive_char(8'h41, 0, 0);
    @(posedge clock); #1;
    check("text_lat", 128'({bus.p1_valid, bus.p1_char}), 128'({1'b1, 8'h41}));
    drive_char(8'h42, 1, 0);
    wait_drain();

    // three stalled cycles in the middle of a glyph
    c = mk(1, 26'h500, 16'h20, 8'd8, 8'd6, 8'd6, 16'd100, 16'd50);
    chs = {8'h7a};
    push_exp(c, chs);
    drive_cmd(c);
    drive_char(8'h7a, 1, 0);
    @(posedge clock); #1 stall_force = 1'b1;
    repeat (3) @(posedge clock);
    #1 stall_force = 1'b0;
    wait_drain();

    // zero height consumes no char and reopens next cycle
    bus.char_valid = 1'b1;
    bus.char_data  = 8'h55;
    bus.char_last  = 1'b1;
    c = mk(1, 26'h40, 16'd1, 8'd8, 8'd8, 8'd0, 16'd0, 16'd0);
    drive_cmd(c);
    check("h0_cmd_ready", 128'(bus.cmd_ready), 128'(1));
    check("h0_busy", 128'(busy), 128'(0));
    check("h0_char_ready", 128'(bus.char_ready), 128'(0));
    bus.char_valid = 1'b0;
    wait_drain();

    // address and dst_y wrap
    chs = {};
    run(mk(0, 26'h3FFFFFF, 16'd1, 8'd2, 8'd0, 8'd2, 16'd9, 16'd1), chs, 0);
    run(mk(0, 26'h10, 16'h100, 8'd2, 8'd0, 8'd2, 16'd9, 16'hFFFF), chs, 0);

    // character starvation in FETCH
    c = mk(1, 26'h800, 16'd2, 8'd12, 8'd5, 8'd2, 16'd20, 16'd30);
    chs = {8'h33};
    push_exp(c, chs);
    drive_cmd(c);
    repeat (5) begin
      @(negedge clock); #1;
      check("starve_valid", 128'(bus.p1_valid), 128'(0));
      check("starve_busy", 128'(busy), 128'(1));
    end
    drive_char(8'h33, 1, 0);
    wait_drain();

    // reset during the second character
    c = mk(1, 26'h900, 16'd4, 8'd16, 8'd8, 8'd4, 16'd0, 16'd0);
    chs = {8'h58, 8'h59};
    push_exp(c, chs);
    drive_cmd(c);
    drive_char(8'h58, 0, 0);
    drive_char(8'h59, 1, 0);
    @(posedge clock); #3 resetn = 1'b0;
    #1;
    check("rst_mid_busy", 128'(busy), 128'(0));
    check("rst_mid_valid", 128'({bus.p1_valid, bus.p1_last}), 128'(0));
    exp_q.delete();
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    chs = {};
    run(mk(0, 26'h1234, 16'h10, 8'd3, 8'd0, 8'd3, 16'd1, 16'd2), chs, 0);

    // randomized commands under random stall
    stall_en = 1'b1;
    for (int k = 0; k < 40; k++) begin
      c = mk($urandom_range(0, 1), 26'($urandom),
             ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom),
             8'($urandom), 8'($urandom), 8'($urandom_range(0, 5)),
             16'($urandom), 16'($urandom));
      chs = {};
      for (int i = 0; i < int'($urandom_range(1, 4)); i++)
        chs.push_back(8'($urandom));
      run(c, chs, $urandom_range(0, 2));
    end
    stall_en = 1'b0;

    repeat (3) @(negedge clock);
    check("final_queue", 128'(exp_q.size()), 128'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
